pipe_add_simd: RTL
==================

// Module: pipe_add_simd
// PURPOSE
//  Pipelined, segmented integer adder/subtractor with SIMD lane modes and a valid/ready handshake.
//  Successor to the combinational add block used in the multiplier-tree datapath.
//  Splits the XLEN carry chain into STAGES registered segments, giving 1 result/cycle at high fclk.
//  Sits after the partial-product reduction tree (final CPA) and serves as a standalone ALU adder.
// PARAMETERS
//  XLEN    32  operand/result width; multiple of 4*STAGES... see rule below
//  STAGES  4   pipeline depth = number of carry segments; power of 2, 4 <= STAGES <= XLEN/8
//  SEG     XLEN/STAGES (localparam) segment width; XLEN % STAGES == 0 (elaboration $error otherwise)
// PORTS
//  clock      in   1     system clock, all state on posedge
//  reset      in   1     synchronous, active-high
//  in_valid   in   1     operand transaction present
//  in_ready   out  1     block accepts transaction this cycle
//  data0      in   XLEN  operand A
//  data1      in   XLEN  operand B
//  op         in   1     0 = A+B, 1 = A-B
//  mode       in   2     0 = 1 lane of XLEN, 1 = 2 lanes of XLEN/2, 2 = 4 lanes of XLEN/4, 3 = reserved (treated as 0)
//  out_valid  out  1     result transaction present
//  out_ready  in   1     consumer accepts result this cycle
//  result     out  XLEN  lane-wise sum/difference, lane 0 in LSBs
//  cout       out  4     carry-out of lane i MSB (raw carry; sub: 1 = no borrow); bits >= lane count are 0
// BEHAVIOUR
//  - Reset: all stage valid bits, out_valid, result, cout = 0; in_ready = 1 after reset. In-flight data discarded.
//  - Accept when in_valid & in_ready. op/mode captured with operands and travel with the transaction,
//    so back-to-back transactions may differ in op/mode.
//  - Latency: exactly STAGES cycles from accept edge to out_valid (no stall).
//  - Stage s (0..STAGES-1) computes segment s: bits [s*SEG +: SEG] of A + (op ? ~B : B) + cin_s.
//    cin_s = op if segment s starts a lane (s*SEG % lane_width == 0), else registered carry of stage s-1.
//    Lane widths are multiples of SEG by the STAGES >= 4 rule, so lane boundaries fall on segment boundaries.
//  - Unprocessed upper operand segments and finished lower result segments ride along (skew registers).
//  - cout[i] = carry out of segment at lane i MSB; captured in the stage that finishes that lane.
//  - Flow control: global enable en = ~out_valid | out_ready; in_ready = en; all stages advance on en.
//    Stall freezes every stage and holds result/cout/out_valid stable; bubbles are not collapsed.
//  - Full throughput 1 transaction/cycle while out_ready = 1; no transaction lost or reordered.
//  - in_valid = 0 inserts a bubble (stage valid 0); datapath registers of bubbles are don't-care but
//    result/cout only update when the transaction reaching the last stage is valid.
//  - Wrap-around: per-lane modular arithmetic, overflow only reported via cout; no saturation.
//  - Reset asserted mid-operation wins over en: pipeline empties the next cycle.
// STRUCTURE
//  - Package configure: XLEN, STAGES defaults; typedef enum logic [1:0] {MODE_X1, MODE_X2, MODE_X4} add_mode_t;
//    typedef struct for a stage register (valid, op, mode, a, b, sum, carry, cout).
//  - Sub-module add_segment: combinational SEG-bit adder (a, b, cin, op) -> (sum, cout); one instance per stage.
//  - Top: generate loop over STAGES stage registers plus enable/handshake logic; lane-start mask from mode.
// TESTING (XLEN=32, STAGES=4, out_ready=1 unless stated)
//  1. A=FFFFFFFF B=00000001 op=0 mode=0 -> result=00000000, cout=0001, out_valid exactly 4 cycles after accept.
//  2. A=00000005 B=00010006 op=1 mode=1 -> result=FFFFFFFF, cout=0000 (both lanes borrow, no carry across lanes).
//  3. A=FF7F0180 B=01010180 op=0 mode=2 -> result=00800200, cout=1001.
//  4. 8 back-to-back accepts, alternating op and mode, out_ready=0 for 3 cycles mid-stream -> in_ready=0
//     while out_valid & ~out_ready, outputs stable during stall, all 8 results in order, none duplicated.
//  5. reset pulsed with 3 transactions in flight -> out_valid=0, result=0, cout=0 next cycle; no stale result later.
//  6. 10k random A/B/op/mode with random in_valid/out_ready -> per-lane result/cout match scoreboard (a+b / a-b),
//     result XOR reference == 0; print TEST SUCCEEDED / TEST FAILED per check.

Source files
------------

// File: rtl/pipe_add_simd_pkg.sv
// Shared types and helpers for the pipelined SIMD adder/subtractor.
// Holds the default geometry, the lane-mode encoding, the per-stage control
// record, and the functions that map a segment index to its lane position.
package pipe_add_simd_pkg;

  localparam int unsigned DefaultXlen   = 32;
  localparam int unsigned DefaultStages = 4;
  localparam int unsigned MaxLanes      = 4;

  typedef enum logic [1:0] {
    MODE_X1 = 2'd0,
    MODE_X2 = 2'd1,
    MODE_X4 = 2'd2
  } add_mode_t;

  // Control part of a stage register; the XLEN-wide a/b/sum vectors are
  // attached in the top, where XLEN is known.
  typedef struct packed {
    logic                valid;
    logic                op;
    add_mode_t           mode;
    logic                carry;  // carry out of the previous segment
    logic [MaxLanes-1:0] cout;   // lane carry-outs collected so far
  } stage_ctrl_t;

  // The reserved encoding 3 behaves as a single full-width lane.
  function automatic add_mode_t decode_mode(logic [1:0] raw);
    add_mode_t m;
    case (raw)
      2'd1:    m = MODE_X2;
      2'd2:    m = MODE_X4;
      default: m = MODE_X1;
    endcase
    return m;
  endfunction

  function automatic int unsigned lane_segs(add_mode_t mode, int unsigned stages);
    int unsigned n;
    case (mode)
      MODE_X2: n = stages / 2;
      MODE_X4: n = stages / 4;
      default: n = stages;
    endcase
    return n;
  endfunction

  function automatic logic seg_starts_lane(add_mode_t mode, int unsigned seg,
                                           int unsigned stages);
    return (seg % lane_segs(mode, stages)) == 0;
  endfunction

  function automatic logic seg_ends_lane(add_mode_t mode, int unsigned seg,
                                         int unsigned stages);
    return ((seg + 1) % lane_segs(mode, stages)) == 0;
  endfunction

  function automatic logic [1:0] seg_lane(add_mode_t mode, int unsigned seg,
                                          int unsigned stages);
    return 2'(seg / lane_segs(mode, stages));
  endfunction

endpackage

// File: rtl/pipe_add_simd_add_segment.sv
// Combinational Width-bit segment of the carry chain.
//   a_i, b_i : operand slices
//   cin_i    : carry into the segment
//   op_i     : 0 = add, 1 = subtract (b is inverted; the +1 arrives via cin_i)
//   sum_o    : segment sum
//   cout_o   : raw carry out of the segment MSB
module add_segment #(
  parameter int unsigned Width = 8
) (
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  input  logic             cin_i,
  input  logic             op_i,
  output logic [Width-1:0] sum_o,
  output logic             cout_o
);

  logic [Width-1:0] b_eff;

  assign b_eff = op_i ? ~b_i : b_i;
  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_eff} + {{Width{1'b0}}, cin_i};

endmodule

// File: rtl/pipe_add_simd.sv
// Pipelined, segmented adder/subtractor with 1/2/4 SIMD lanes.
//   clock, reset        : clock and synchronous active-high reset
//   in_valid/in_ready   : operand handshake (data0 = A, data1 = B, op, mode)
//   out_valid/out_ready : result handshake (result, cout)
// The carry chain is split into STAGES segments, one per pipeline stage.
// A capture register feeds stage 0; stage s adds segment s and passes the
// carry on, and the last stage writes the output register, giving a latency
// of STAGES cycles. All stages advance together on a single global enable.
module pipe_add_simd
  import pipe_add_simd_pkg::*;
#(
  parameter int unsigned XLEN   = DefaultXlen,
  parameter int unsigned STAGES = DefaultStages
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   data0,
  input  logic [XLEN-1:0]   data1,
  input  logic              op,
  input  logic [1:0]        mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   result,
  output logic [3:0]        cout
);

  localparam int unsigned SEG = XLEN / STAGES;

  if (XLEN % STAGES != 0) begin : g_bad_split
    $error("pipe_add_simd: XLEN must be a multiple of STAGES");
  end
  if (STAGES < 4 || STAGES > XLEN / 8 || (STAGES & (STAGES - 1)) != 0) begin : g_bad_stages
    $error("pipe_add_simd: STAGES must be a power of 2 in [4, XLEN/8]");
  end

  typedef struct packed {
    stage_ctrl_t     ctrl;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] sum;
  } stage_t;

  // pipe_d[s] is the next value of pipe_q[s]; pipe_d[STAGES] feeds the outputs.
  stage_t pipe_q [STAGES];
  stage_t pipe_d [STAGES+1];

  logic            en;
  logic            out_valid_q;
  logic [XLEN-1:0] result_q;
  logic [3:0]      cout_q;

  assign en        = ~out_valid_q | out_ready;
  assign in_ready  = en;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign cout      = cout_q;

  always_comb begin
    pipe_d[0]            = '0;
    pipe_d[0].ctrl.valid = in_valid;
    pipe_d[0].ctrl.op    = op;
    pipe_d[0].ctrl.mode  = decode_mode(mode);
    pipe_d[0].a          = data0;
    pipe_d[0].b          = data1;
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    logic           cin;
    logic           seg_cout;
    logic [SEG-1:0] seg_sum;

    // A lane start injects op (the +1 of two's complement); otherwise the
    // carry ripples in from the previous segment.
    assign cin = seg_starts_lane(pipe_q[s].ctrl.mode, s, STAGES) ? pipe_q[s].ctrl.op
                                                                 : pipe_q[s].ctrl.carry;

    add_segment #(
      .Width(SEG)
    ) u_seg (
      .a_i   (pipe_q[s].a[s*SEG +: SEG]),
      .b_i   (pipe_q[s].b[s*SEG +: SEG]),
      .cin_i (cin),
      .op_i  (pipe_q[s].ctrl.op),
      .sum_o (seg_sum),
      .cout_o(seg_cout)
    );

    always_comb begin
      pipe_d[s+1]                    = pipe_q[s];
      pipe_d[s+1].sum[s*SEG +: SEG]  = seg_sum;
      pipe_d[s+1].ctrl.carry         = seg_cout;
      if (seg_ends_lane(pipe_q[s].ctrl.mode, s, STAGES)) begin
        pipe_d[s+1].ctrl.cout[seg_lane(pipe_q[s].ctrl.mode, s, STAGES)] = seg_cout;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int s = 0; s < STAGES; s++) begin
        pipe_q[s] <= '0;
      end
      out_valid_q <= 1'b0;
      result_q    <= '0;
      cout_q      <= '0;
    end else if (en) begin
      for (int s = 0; s < STAGES; s++) begin
        pipe_q[s] <= pipe_d[s];
      end
      out_valid_q <= pipe_d[STAGES].ctrl.valid;
      // Bubbles leave the last visible result in place.
      if (pipe_d[STAGES].ctrl.valid) begin
        result_q <= pipe_d[STAGES].sum;
        cout_q   <= pipe_d[STAGES].ctrl.cout;
      end
    end
  end

endmodule
